// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and load sequencer for a shared WIDTH-bit register.
// One requester is granted, its word loaded into Q, and acknowledged per 3-cycle round.
module dff_bank_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N-1:0]           i_req,
    input  logic [N*WIDTH-1:0]     i_data,
    output logic [N-1:0]           o_gnt,
    output logic [N-1:0]           o_ack,
    output logic [WIDTH-1:0]       o_q,
    output logic                   o_busy,
    output logic [$clog2(N)-1:0]   o_last_id
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     w_gnt_nxt;
    logic [N-1:0]     r_ack;
    logic [N-1:0]     w_ack_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_busy;
    logic [IW-1:0]    r_last_id;
    logic [IW-1:0]    w_last_id_nxt;
    logic [IW-1:0]    r_win;
    logic [IW-1:0]    w_win_nxt;

    logic             w_found;
    logic [IW-1:0]    w_arb_win;
    logic [N-1:0]     w_arb_onehot;
    logic [N-1:0]     w_win_onehot;
    logic [WIDTH-1:0] w_win_data;

    // Rotating-priority search: first requester after the last one served, wrapping mod N.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_found   = 1'b0;
        w_arb_win = '0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(r_last_id) + k) % N;
            if (!w_found && i_req[IW'(idx)]) begin
                w_found   = 1'b1;
                w_arb_win = IW'(idx);
            end
        end
    end

    always_comb begin
        w_arb_onehot            = '0;
        w_arb_onehot[w_arb_win] = 1'b1;
        w_win_onehot            = '0;
        w_win_onehot[r_win]     = 1'b1;
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_win == IW'(i)) begin
                w_win_data = i_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = '0;
        w_ack_nxt     = '0;
        w_q_nxt       = r_q;
        w_last_id_nxt = r_last_id;
        w_win_nxt     = r_win;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_arb_onehot;
                    w_win_nxt   = w_arb_win;
                end
            end
            GRANT: begin
                // Only the granted line matters here; a dropped request aborts without loading.
                if (i_req[r_win]) begin
                    w_state_nxt   = ACK;
                    w_q_nxt       = w_win_data;
                    w_last_id_nxt = r_win;
                    w_ack_nxt     = w_win_onehot;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ACK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_q       <= '0;
            r_busy    <= 1'b0;
            r_last_id <= IW'(N - 1);
            r_win     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_ack     <= w_ack_nxt;
            r_q       <= w_q_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_last_id <= w_last_id_nxt;
            r_win     <= w_win_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_ack     = r_ack;
    assign o_q       = r_q;
    assign o_busy    = r_busy;
    assign o_last_id = r_last_id;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and load sequencer for a shared WIDTH-bit bank of D flip-flops.
- Up to N requesters each present a data word and a request line.
- The block grants one requester at a time, loads that requester's word into the shared register Q, and acknowledges it.
- Sits between requester logic and the shared storage register; it is the only writer of Q.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, width of each data word and of Q

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  asynchronous, active-high; clears all state immediately
Req  input  N  Req[i] high = requester i wants to load its word
Data  input  N*WIDTH  Data[i*WIDTH +: WIDTH] = word of requester i
Gnt  output  N  one-hot registered grant; all zero when no grant
Ack  output  N  one-cycle pulse to the requester whose word was loaded
Q  output  WIDTH  shared register contents
Busy  output  1  high in GRANT and ACK states
LastId  output  $clog2(N)  index of last requester successfully loaded

Behaviour:
- Reset values: state IDLE, Gnt=0, Ack=0, Q=0, Busy=0, LastId=N-1 (requester 0 has top priority after reset). Reset is asynchronous: asserting it in any state, mid-transfer included, forces these values at once. No partial load of Q occurs.
- FSM states: IDLE, GRANT, ACK. All outputs are registered.
- IDLE:
  - If any Req bit is high on a rising edge, select winner w = first i with Req[i]=1, searching LastId+1, LastId+2, ... with wrap modulo N.
  - Next state GRANT, Gnt = one-hot(w), and w is latched internally.
  - If Req=0, stay in IDLE.
- GRANT (exactly one cycle, Gnt[w]=1):
  - If Req[w] is still high on the edge: Q <= Data[w] sampled on that edge, LastId <= w, next state ACK, Gnt <= 0, Ack[w] <= 1.
  - If Req[w] has dropped (abort): Q, LastId and Ack are unchanged, Gnt <= 0, next state IDLE.
  - Req changes on other lines during GRANT are ignored.
- ACK (exactly one cycle, Ack[w]=1, Gnt=0):
  - Next state IDLE, Ack <= 0.
  - A requester still holding Req during ACK is treated as a new request in IDLE and competes normally.
- Latency: Req rising in cycle t → Gnt at t+1 → Q updated and Ack at t+2 → IDLE at t+3. Peak throughput is one load per 3 cycles.
- Fairness: LastId updates only on a successful load. A requester that holds Req continuously is served within N transfers.
- Simultaneous requests are resolved purely by the rotating priority; there is no fixed priority.
- Q changes only on the GRANT→ACK edge and holds its value indefinitely otherwise.
- Gnt and Ack are never high in the same cycle. At most one bit of each is high at any time.
- Busy = (state != IDLE).
- An X or undefined requester index cannot occur: w is always latched from a valid one-hot selection.

Test Plan:
- Reset: Reset=1 with random Req/Data, release → Q=0x00, Gnt=0000, Ack=0000, Busy=0, LastId=3. Assert Reset during GRANT → all outputs return to reset values in the same cycle and Q is unchanged from 0.
- Single request: Req=0010, Data[1]=0xA5, held until Ack → Gnt=0010 one cycle later, next cycle Q=0xA5, Ack=0010, LastId=1, then IDLE with Busy=0.
- Round robin: Req=1111 held, Data[i]=0x10+i → load order 0,1,2,3,0, Q sequence 0x10,0x11,0x12,0x13,0x10, one Ack pulse every 3 cycles.
- Wrap and skip: LastId=2, Req=0011 → requester 0 wins before requester 1; then Req=0010 only → requester 1 wins.
- Abort: Req=0100 for one cycle only, dropped during GRANT → no Ack, Q unchanged, LastId unchanged, back to IDLE; the next Req=0100 is granted normally.
- Late competitor: while requester 2 is in GRANT, Req[0] rises → requester 2 still loaded; requester 0 is granted in the following arbitration round.
